// File: rtl/pairwise_xnor_matrix_pkg.sv
// Shared types and index helpers for the pairwise XNOR/XOR compare matrix.
// Element k sits at [(N-1-k)*W +: W]; slot (i,j) at [(N*N-1-(i*N+j))*W +: W].
package pairwise_xnor_pkg;

  typedef enum logic {
    CMP_XNOR = 1'b0,
    CMP_XOR  = 1'b1
  } cmp_mode_e;

  function automatic int pop_w(input int n, input int w);
    return (w < 1) ? 1 : $clog2(n * n + 1);
  endfunction

  function automatic int elem_lsb(input int n, input int w, input int k);
    return (n - 1 - k) * w;
  endfunction

  function automatic int slot_lsb(input int n, input int w, input int i, input int j);
    return (n * n - 1 - (i * n + j)) * w;
  endfunction

endpackage

// File: rtl/pairwise_xnor_matrix_if.sv
// Beat-in / matrix-out valid-ready bundle for pairwise_xnor_matrix.
// master = upstream/downstream side, slave = the comparator block.
interface pairwise_xnor_if
  import pairwise_xnor_pkg::*;
#(
    parameter int N     = 5,
    parameter int W     = 1,
    parameter int CNT_W = 16
) ();
    localparam int PCW = pop_w(N, W);

    logic               in_valid;
    logic               in_ready;
    logic [N*W-1:0]     in_data;
    cmp_mode_e          in_mode;
    logic               out_valid;
    logic               out_ready;
    logic [N*N*W-1:0]   out_matrix;
    logic               out_all_eq;
    logic [PCW-1:0]     out_popcount;
    logic [CNT_W-1:0]   out_beats;

    modport master (
        output in_valid, in_data, in_mode, out_ready,
        input  in_ready, out_valid, out_matrix, out_all_eq, out_popcount, out_beats
    );

    modport slave (
        input  in_valid, in_data, in_mode, out_ready,
        output in_ready, out_valid, out_matrix, out_all_eq, out_popcount, out_beats
    );
endinterface

// File: rtl/pairwise_xnor_matrix_core.sv
// Combinational compare matrix, all-equal flag and equal-pair popcount.
// Popcount is built only when PAIRWISE_XNOR_POPCOUNT_EN is defined; otherwise tied to 0.
module pairwise_xnor_core
  import pairwise_xnor_pkg::*;
#(
    parameter int N = 5,
    parameter int W = 1
) (
    input  logic [N*W-1:0]          data,
    input  cmp_mode_e               mode,
    output logic [N*N*W-1:0]        matrix,
    output logic                    all_eq,
    output logic [pop_w(N,W)-1:0]   popcount
);
    localparam int PCW = pop_w(N, W);

    logic [W-1:0] diff;

    always_comb begin
        matrix = '0;
        all_eq = 1'b1;
        diff   = '0;
        for (int i = 0; i < N; i++) begin
            if (data[elem_lsb(N, W, i) +: W] != data[elem_lsb(N, W, 0) +: W])
                all_eq = 1'b0;
            for (int j = 0; j < N; j++) begin
                diff = data[elem_lsb(N, W, i) +: W] ^ data[elem_lsb(N, W, j) +: W];
                matrix[slot_lsb(N, W, i, j) +: W] = (mode == CMP_XOR) ? diff : ~diff;
            end
        end
    end

`ifdef PAIRWISE_XNOR_POPCOUNT_EN
    // Whole-element equality; the diagonal always contributes N.
    always_comb begin
        popcount = '0;
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
                if (data[elem_lsb(N, W, i) +: W] == data[elem_lsb(N, W, j) +: W])
                    popcount = popcount + PCW'(1);
    end
`else
    assign popcount = '0;
`endif

endmodule

// File: rtl/pairwise_xnor_matrix.sv
// Two-stage valid/ready pairwise comparator: S1 captures the beat, S2 holds the matrix/flags.
// Optional popcount controlled by PAIRWISE_XNOR_POPCOUNT_EN (see pairwise_xnor_core).
module pairwise_xnor_matrix
  import pairwise_xnor_pkg::*;
#(
    parameter int N     = 5,
    parameter int W     = 1,
    parameter int CNT_W = 16
) (
    input  logic            clk,
    input  logic            reset,
    pairwise_xnor_if.slave  bus
);
    localparam int MW  = N * N * W;
    localparam int PCW = pop_w(N, W);

    logic               vld_p1, vld_p2;
    logic               adv_p1, adv_p2;
    logic [N*W-1:0]     data_p1;
    cmp_mode_e          mode_p1;
    logic [MW-1:0]      matrix_c, matrix_p2;
    logic               all_eq_c, all_eq_p2;
    logic [PCW-1:0]     pop_c, pop_p2;
    logic [CNT_W-1:0]   beats;

    // A stage may load when empty or when its contents leave on this edge.
    assign adv_p2      = !vld_p2 || bus.out_ready;
    assign adv_p1      = !vld_p1 || adv_p2;
    assign bus.in_ready = adv_p1;

    // S1: beat capture
    always_ff @(posedge clk or posedge reset) begin
        if (reset)       vld_p1 <= 1'b0;
        else if (adv_p1) vld_p1 <= bus.in_valid;
    end

    always_ff @(posedge clk) begin
        if (adv_p1 && bus.in_valid) begin
            data_p1 <= bus.in_data;
            mode_p1 <= bus.in_mode;
        end
    end

    pairwise_xnor_core #(.N(N), .W(W)) u_core (
        .data     (data_p1),
        .mode     (mode_p1),
        .matrix   (matrix_c),
        .all_eq   (all_eq_c),
        .popcount (pop_c)
    );

    // S2: result registers and output transfer counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_p2    <= 1'b0;
            matrix_p2 <= '0;
            all_eq_p2 <= 1'b0;
            pop_p2    <= '0;
            beats     <= '0;
        end else begin
            if (adv_p2) begin
                vld_p2 <= vld_p1;
                if (vld_p1) begin
                    matrix_p2 <= matrix_c;
                    all_eq_p2 <= all_eq_c;
                    pop_p2    <= pop_c;
                end
            end
            if (vld_p2 && bus.out_ready)
                beats <= beats + CNT_W'(1);
        end
    end

    assign bus.out_valid    = vld_p2;
    assign bus.out_matrix   = matrix_p2;
    assign bus.out_all_eq   = all_eq_p2;
    assign bus.out_popcount = pop_p2;
    assign bus.out_beats    = beats;

endmodule
